// File: rtl/gb_bus_pkg.sv
// Shared types and address-map constants for the Game Boy cartridge bus master.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } gb_bus_state_e;

  localparam logic [15:0] BANK_SEL_LO = 16'h2000;
  localparam logic [15:0] BANK_SEL_HI = 16'h3FFF;
  localparam logic [15:0] XRAM_LO     = 16'hA000;
  localparam logic [15:0] XRAM_HI     = 16'hBFFF;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } gb_bus_req_t;

  function automatic logic addr_in_range(input logic [15:0] addr,
                                         input logic [15:0] lo,
                                         input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/gb_bus_phase_timer.sv
// Loadable 8-bit down-counter timing one bus phase; done is high in the
// final cycle of the phase (load with phase_length - 1 on phase entry).
module gb_bus_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == 8'd0);

endmodule

// File: rtl/gb_cart_bus_master.sv
// Console-side Game Boy cartridge bus initiator: SETUP/STROBE/HOLD cycles per request.
// Optional macro BANK_SEL_CACHE_EN skips repeated identical ROM-bank-select writes.
import gb_bus_pkg::*;

module gb_cart_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_cs_n,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in
);

  localparam logic [7:0] SETUP_M1  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_M1 = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_M1   = 8'(HOLD_CYCLES - 1);

  gb_bus_state_e state, state_nxt;
  gb_bus_req_t   req_in, req_q, req_cur;
  logic          accept, cache_hit, hit_q;
  logic          tmr_load, tmr_done;
  logic [7:0]    tmr_value;
  logic [7:0]    rd_cap;

  logic [15:0]   addr_d;
  logic          rd_n_d, wr_n_d, cs_n_d, oe_d, rsp_d, rsp_load;
  logic [7:0]    dout_d, rdata_d;

  assign req_in  = {req_write, req_addr, req_wdata};
  assign accept  = req_valid && req_ready;
  assign req_cur = accept ? req_in : req_q;

  gb_bus_phase_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

`ifdef BANK_SEL_CACHE_EN
  logic [4:0] bank_cache;
  logic       bank_valid;
  logic       bank_wr;

  assign bank_wr   = accept && req_write && addr_in_range(req_addr, BANK_SEL_LO, BANK_SEL_HI);
  assign cache_hit = bank_wr && bank_valid && (req_wdata[4:0] == bank_cache);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_cache <= '0;
      bank_valid <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      hit_q <= cache_hit;
      if (bank_wr && !cache_hit) begin
        bank_cache <= req_wdata[4:0];
        bank_valid <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_q     = 1'b0;
`endif

  // A cache hit completes IDLE -> IDLE, so ready drops for its response cycle.
  assign req_ready = (state == IDLE) && !hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: begin
        if (accept && !cache_hit) begin
          state_nxt = SETUP;
          tmr_load  = 1'b1;
          tmr_value = SETUP_M1;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_nxt = STROBE;
          tmr_load  = 1'b1;
          tmr_value = STROBE_M1;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_nxt = HOLD;
          tmr_load  = 1'b1;
          tmr_value = HOLD_M1;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus values are derived from the upcoming state and then registered.
  always_comb begin
    addr_d   = '0;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    cs_n_d   = 1'b1;
    oe_d     = 1'b0;
    dout_d   = '0;
    rsp_d    = 1'b0;
    rsp_load = 1'b0;
    rdata_d  = '0;
    if (state_nxt != IDLE) begin
      addr_d = req_cur.addr;
      cs_n_d = !addr_in_range(req_cur.addr, XRAM_LO, XRAM_HI);
      oe_d   = req_cur.write;
      dout_d = req_cur.write ? req_cur.wdata : 8'h00;
      if (state_nxt == STROBE) begin
        rd_n_d = req_cur.write;
        wr_n_d = !req_cur.write;
      end
    end
    if (state == HOLD && tmr_done) begin
      rsp_d    = 1'b1;
      rsp_load = 1'b1;
      rdata_d  = req_q.write ? 8'h00 : rd_cap;
    end else if (cache_hit) begin
      rsp_d    = 1'b1;
      rsp_load = 1'b1;
      rdata_d  = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      rd_cap       <= '0;
      bus_addr     <= '0;
      bus_rd_n     <= 1'b1;
      bus_wr_n     <= 1'b1;
      bus_cs_n     <= 1'b1;
      bus_data_oe  <= 1'b0;
      bus_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      if (accept) begin
        req_q <= req_in;
      end
      // Cartridge data is captured only on the edge that ends the read strobe.
      if (state == STROBE && tmr_done && !req_q.write) begin
        rd_cap <= bus_data_in;
      end
      bus_addr     <= addr_d;
      bus_rd_n     <= rd_n_d;
      bus_wr_n     <= wr_n_d;
      bus_cs_n     <= cs_n_d;
      bus_data_oe  <= oe_d;
      bus_data_out <= dout_d;
      rsp_valid    <= rsp_d;
      if (rsp_load) begin
        rsp_rdata <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Scoreboard bench for gb_cart_bus_master with a small cartridge/MBC1 model.
// Define BANK_SEL_CACHE_EN on both RTL and bench to exercise the bank-select cache.
module tb_gb_cart_bus_master;

  localparam int SETUP_N  = 2;
  localparam int STROBE_N = 3;
  localparam int HOLD_N   = 1;
  localparam int TXN_N    = SETUP_N + STROBE_N + HOLD_N;
  localparam int NT       = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd_n, bus_wr_n, bus_cs_n, bus_data_oe;
  logic [7:0]  bus_data_out, bus_data_in;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  exp_q[$];
  logic [4:0]  mbc_bank = 5'd1;

  logic        tr_rd[NT], tr_wr[NT], tr_cs[NT], tr_oe[NT], tr_rv[NT], tr_rdy[NT];
  logic [15:0] tr_addr[NT];
  logic [7:0]  tr_do[NT], tr_rdata[NT];

  gb_cart_bus_master #(
    .SETUP_CYCLES (SETUP_N),
    .STROBE_CYCLES(STROBE_N),
    .HOLD_CYCLES  (HOLD_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .bus_addr    (bus_addr),
    .bus_rd_n    (bus_rd_n),
    .bus_wr_n    (bus_wr_n),
    .bus_cs_n    (bus_cs_n),
    .bus_data_out(bus_data_out),
    .bus_data_oe (bus_data_oe),
    .bus_data_in (bus_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cart_read(input logic [15:0] a);
    if (a == 16'h0150) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Cartridge drives data only while rd_n is low.
  assign bus_data_in = !bus_rd_n ? cart_read(bus_addr) : 8'hFF;

  always @(posedge clk) begin
    if (!bus_wr_n && bus_addr >= 16'h2000 && bus_addr <= 16'h3FFF)
      mbc_bank <= (bus_data_out[4:0] == 5'd0) ? 5'd1 : bus_data_out[4:0];
  end

  // Expected {rd_n, wr_n, cs_n, oe, rsp_valid, addr, data_out} j cycles after an accept edge.
  function automatic logic [28:0] exp_bus(input logic w, input logic [15:0] a,
                                          input logic [7:0] d, input int j);
    logic active, strobe;
    active = (j >= 0) && (j < TXN_N);
    strobe = (j >= SETUP_N) && (j < SETUP_N + STROBE_N);
    return {!(strobe && !w), !(strobe && w), !(active && a >= 16'hA000 && a <= 16'hBFFF),
            active && w, (j == TXN_N), active ? a : 16'h0000, (active && w) ? d : 8'h00};
  endfunction

  task automatic sample(input int j);
    tr_rd[j]    = bus_rd_n;
    tr_wr[j]    = bus_wr_n;
    tr_cs[j]    = bus_cs_n;
    tr_oe[j]    = bus_data_oe;
    tr_rv[j]    = rsp_valid;
    tr_rdy[j]   = req_ready;
    tr_addr[j]  = bus_addr;
    tr_do[j]    = bus_data_out;
    tr_rdata[j] = rsp_rdata;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL req_ready_timeout got=0 exp=1");
    end
  endtask

  task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(w ? 8'h00 : cart_read(a));
    #1 req_valid = 1'b0;
    for (int j = 0; j < NT; j++) begin
      @(negedge clk);
      sample(j);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, bus_addr, bus_rd_n, bus_wr_n, bus_cs_n, bus_data_out, bus_data_oe}
        !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values got=%h exp=%h",
               {req_ready, rsp_valid, rsp_rdata, bus_addr, bus_rd_n, bus_wr_n, bus_cs_n, bus_data_out, bus_data_oe},
               {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_txn(input string name, input logic w, input logic [15:0] a, input logic [7:0] d);
    logic [28:0] got, exp;
    logic [7:0]  e;
    run_txn(w, a, d);
    for (int j = 0; j < NT; j++) begin
      got = {tr_rd[j], tr_wr[j], tr_cs[j], tr_oe[j], tr_rv[j], tr_addr[j], tr_do[j]};
      exp = exp_bus(w, a, d, j);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s_bus j=%0d got=%h exp=%h", name, j, got, exp);
      end
      if (tr_rv[j]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s_unexpected_rsp j=%0d got=%h exp=none", name, j, tr_rdata[j]);
        end else begin
          e = exp_q.pop_front();
          if (tr_rdata[j] !== e) begin
            miscompares++;
            $display("FAIL %s_rdata j=%0d got=%h exp=%h", name, j, tr_rdata[j], e);
          end
        end
      end
    end
  endtask

  task automatic test_write_bank;
    test_txn("wr_bank", 1'b1, 16'h2000, 8'h05);
    vectors++;
    if (mbc_bank !== 5'd5) begin
      miscompares++;
      $display("FAIL mbc_bank got=%0d exp=5", mbc_bank);
    end
  endtask

  task automatic test_back_to_back;
    bit          ok;
    int          acc2;
    logic [28:0] got, exp;
    logic [7:0]  e;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000; req_wdata = 8'h00;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(cart_read(16'h4000));
    #1 req_addr = 16'h4001;
    acc2 = -1;
    for (int j = 0; j < NT; j++) begin
      @(negedge clk);
      sample(j);
      if (acc2 < 0 && req_valid && req_ready) begin
        acc2 = j;
        exp_q.push_back(cart_read(16'h4001));
      end else if (acc2 >= 0) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (acc2 != TXN_N) begin
      miscompares++;
      $display("FAIL b2b_second_accept got=%0d exp=%0d", acc2, TXN_N);
    end
    for (int j = 0; j < NT; j++) begin
      got = {tr_rd[j], tr_wr[j], tr_cs[j], tr_oe[j], tr_rv[j], tr_addr[j], tr_do[j]};
      exp = (j <= TXN_N) ? exp_bus(1'b0, 16'h4000, 8'h00, j)
                         : exp_bus(1'b0, 16'h4001, 8'h00, j - TXN_N - 1);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL b2b_bus j=%0d got=%h exp=%h", j, got, exp);
      end
      if (tr_rv[j]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_unexpected_rsp j=%0d got=%h exp=none", j, tr_rdata[j]);
        end else begin
          e = exp_q.pop_front();
          if (tr_rdata[j] !== e) begin
            miscompares++;
            $display("FAIL b2b_rdata j=%0d got=%h exp=%h", j, tr_rdata[j], e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0150; req_wdata = 8'h00;
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (SETUP_N + 2) @(negedge clk);
    vectors++;
    if (bus_rd_n !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_in_strobe got=%b exp=0", bus_rd_n);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_rd_n, bus_wr_n, bus_addr, bus_data_oe, req_ready, bus_cs_n}
        !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_bus got=%h exp=%h",
               {bus_rd_n, bus_wr_n, bus_addr, bus_data_oe, req_ready, bus_cs_n},
               {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1});
    end
    rst = 1'b0;
    rsp_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    vectors++;
    if (rsp_cnt != 0) begin
      miscompares++;
      $display("FAIL rstmid_rsp_count got=%0d exp=0", rsp_cnt);
    end
  endtask

`ifdef BANK_SEL_CACHE_EN
  task automatic test_bank_cache;
    int          wr_cnt;
    logic [7:0]  e;
    logic [15:0] step;
    // Write 0x03 (miss), 0x03 again (hit), then 0x04 (miss).
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b1, 16'h2000, (k == 2) ? 8'h04 : 8'h03);
      wr_cnt = 0;
      for (int j = 0; j < NT; j++) if (!tr_wr[j]) wr_cnt++;
      vectors++;
      if (wr_cnt != ((k == 1) ? 0 : STROBE_N)) begin
        miscompares++;
        $display("FAIL cache_wr_cycles k=%0d got=%0d exp=%0d", k, wr_cnt, (k == 1) ? 0 : STROBE_N);
      end
      for (int j = 0; j < NT; j++) begin
        vectors++;
        if (tr_rv[j] !== ((k == 1) ? (j == 0) : (j == TXN_N))) begin
          miscompares++;
          $display("FAIL cache_rsp_timing k=%0d j=%0d got=%b", k, j, tr_rv[j]);
        end
        if (tr_rv[j]) begin
          vectors++;
          e = (exp_q.size() == 0) ? 8'hXX : exp_q.pop_front();
          if (tr_rdata[j] !== e) begin
            miscompares++;
            $display("FAIL cache_rdata k=%0d got=%h exp=%h", k, tr_rdata[j], e);
          end
        end
      end
      if (k == 1) begin
        step = {tr_rdy[0], tr_rdy[1], 14'h0};
        vectors++;
        if (step !== 16'h4000) begin
          miscompares++;
          $display("FAIL cache_ready got=%h exp=4000", step);
        end
      end
    end
    vectors++;
    if (mbc_bank !== 5'd4) begin
      miscompares++;
      $display("FAIL cache_mbc_bank got=%0d exp=4", mbc_bank);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    test_reset();
    test_txn("rd_rom", 1'b0, 16'h0150, 8'h00);
    test_write_bank();
    test_txn("rd_xram", 1'b0, 16'hA010, 8'h00);
    test_back_to_back();
    test_reset_mid();
    test_txn("rd_after_rst", 1'b0, 16'h0150, 8'h00);
    test_txn("wr_xram", 1'b1, 16'hBFFF, 8'hA5);
    test_txn("rd_ffff", 1'b0, 16'hFFFF, 8'h00);
    test_txn("rd_0000", 1'b0, 16'h0000, 8'h00);
`ifdef BANK_SEL_CACHE_EN
    test_bank_cache();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
